// File: rtl/prog_tick_timer_pkg.sv
// Shared types and helpers for the programmable tick timer.
// Channel state encoding and prescaler divisor/width math.
package prog_tick_timer_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } chan_state_t;

    // Clock cycles per base tick (integer truncation).
    function automatic int calc_div(input int clk_hz, input int tick_hz);
        return clk_hz / tick_hz;
    endfunction

    // Width of the prescaler counter that spans 0..div-1.
    // Clamped to 1 so a bad divisor still elaborates far enough
    // for the divisor check in the top to report it.
    function automatic int calc_pw(input int div);
        return (div < 2) ? 1 : $clog2(div);
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running base-tick prescaler.
// Ports: CLK, RST (sync, active-high), EN (freeze when low),
//        tick (registered 1-cycle pulse every DIV enabled cycles).
module tick_prescaler
    import prog_tick_timer_pkg::*;
#(
    parameter int DIV = 10
) (
    input  logic CLK,
    input  logic RST,
    input  logic EN,
    output logic tick
);

    localparam int            PW   = calc_pw(DIV);
    localparam logic [PW-1:0] LAST = PW'(DIV - 1);
    localparam logic [PW-1:0] ONE  = PW'(1);

    logic [PW-1:0] cnt;

    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else if (EN) begin
            if (cnt == LAST) begin
                cnt  <= '0;
                tick <= 1'b1;
            end else begin
                cnt  <= cnt + ONE;
                tick <= 1'b0;
            end
        end else begin
            tick <= 1'b0;
        end
    end

endmodule

// File: rtl/prog_tick_timer.sv
// Multi-channel programmable timer driven by a shared base tick.
// Ports: CLK, RST (sync, active-high), EN (prescaler enable),
//        start/stop/periodic (per channel), load_val (packed counts),
//        tick (base tick), expired (1-cycle pulse), busy (in RUN),
//        remaining (packed current counts, same layout as load_val).
module prog_tick_timer
    import prog_tick_timer_pkg::*;
#(
    parameter int CLK_HZ  = 50_000_000,
    parameter int TICK_HZ = 1_000,
    parameter int NUM_CH  = 4,
    parameter int CNT_W   = 16
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    EN,
    input  logic [NUM_CH-1:0]       start,
    input  logic [NUM_CH-1:0]       stop,
    input  logic [NUM_CH-1:0]       periodic,
    input  logic [NUM_CH*CNT_W-1:0] load_val,
    output logic                    tick,
    output logic [NUM_CH-1:0]       expired,
    output logic [NUM_CH-1:0]       busy,
    output logic [NUM_CH*CNT_W-1:0] remaining
);

    localparam int DIV = calc_div(CLK_HZ, TICK_HZ);

    if (DIV < 2) begin : g_div_chk
        $error("prog_tick_timer: CLK_HZ/TICK_HZ must be at least 2");
    end

    if (NUM_CH < 1 || NUM_CH > 16) begin : g_ch_chk
        $error("prog_tick_timer: NUM_CH must be in 1..16");
    end

    tick_prescaler #(
        .DIV (DIV)
    ) u_presc (
        .CLK  (CLK),
        .RST  (RST),
        .EN   (EN),
        .tick (tick)
    );

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch

        chan_state_t      state_q, state_d;
        logic [CNT_W-1:0] rem_q, rem_d;
        logic [CNT_W-1:0] rld_q, rld_d;
        logic             mode_q, mode_d;
        logic             exp_q, exp_d;
        logic [CNT_W-1:0] ld;
        logic             ld_ok;

        assign ld    = load_val[i*CNT_W +: CNT_W];
        assign ld_ok = start[i] && (ld != '0);

        always_ff @(posedge CLK) begin
            if (RST) begin
                state_q <= IDLE;
                rem_q   <= '0;
                rld_q   <= '0;
                mode_q  <= 1'b0;
                exp_q   <= 1'b0;
            end else begin
                state_q <= state_d;
                rem_q   <= rem_d;
                rld_q   <= rld_d;
                mode_q  <= mode_d;
                exp_q   <= exp_d;
            end
        end

        // stop beats start beats tick; a zero load is never accepted.
        always_comb begin
            state_d = state_q;
            rem_d   = rem_q;
            rld_d   = rld_q;
            mode_d  = mode_q;
            exp_d   = 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (!stop[i] && ld_ok) begin
                        rem_d   = ld;
                        rld_d   = ld;
                        mode_d  = periodic[i];
                        state_d = RUN;
                    end
                end
                RUN: begin
                    if (stop[i]) begin
                        rem_d   = '0;
                        state_d = IDLE;
                    end else if (ld_ok) begin
                        rem_d  = ld;
                        rld_d  = ld;
                        mode_d = periodic[i];
                    end else if (tick) begin
                        if (rem_q != ONE) begin
                            rem_d = rem_q - ONE;
                        end else begin
                            exp_d = 1'b1;
                            if (mode_q) begin
                                rem_d = rld_q;
                            end else begin
                                rem_d   = '0;
                                state_d = IDLE;
                            end
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                    rem_d   = '0;
                end
            endcase
        end

        assign busy[i]                      = (state_q == RUN);
        assign expired[i]                   = exp_q;
        assign remaining[i*CNT_W +: CNT_W]  = rem_q;

    end

endmodule

// File: tb/tb_prog_tick_timer.sv
// Self-checking bench for prog_tick_timer.
// Directed tables and sequences, then random traffic against a model.
module tb_prog_tick_timer;

    localparam int CLK_HZ  = 1000;
    localparam int TICK_HZ = 100;
    localparam int NUM_CH  = 2;
    localparam int CNT_W   = 8;
    localparam int DIV     = CLK_HZ / TICK_HZ;

    logic                    CLK = 1'b0;
    logic                    RST;
    logic                    EN;
    logic [NUM_CH-1:0]       start;
    logic [NUM_CH-1:0]       stop;
    logic [NUM_CH-1:0]       periodic;
    logic [NUM_CH*CNT_W-1:0] load_val;
    logic                    tick;
    logic [NUM_CH-1:0]       expired;
    logic [NUM_CH-1:0]       busy;
    logic [NUM_CH*CNT_W-1:0] remaining;

    always #5 CLK = ~CLK;

    prog_tick_timer #(
        .CLK_HZ  (CLK_HZ),
        .TICK_HZ (TICK_HZ),
        .NUM_CH  (NUM_CH),
        .CNT_W   (CNT_W)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .EN        (EN),
        .start     (start),
        .stop      (stop),
        .periodic  (periodic),
        .load_val  (load_val),
        .tick      (tick),
        .expired   (expired),
        .busy      (busy),
        .remaining (remaining)
    );

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;
    bit model_on = 1'b0;

    // Reference model state
    int m_en_edges;
    bit m_tick;
    bit m_run [NUM_CH];
    int m_rem [NUM_CH];
    int m_rld [NUM_CH];
    bit m_per [NUM_CH];
    bit m_exp [NUM_CH];

    typedef struct {
        int gap_at;
        int gap_len;
        int t [3];
    } pv_t;

    pv_t tbl [3];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0d, expected %0d",
                     nm, cyc, act, exp);
        end
    endtask

    // Tick after edge k iff EN at edge k and the count of enabled
    // edges since reset is a multiple of DIV.
    task automatic model_edge();
        bit nt;
        int ld;
        if (RST) begin
            m_en_edges = 0;
            m_tick     = 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                m_run[i] = 1'b0;
                m_rem[i] = 0;
                m_rld[i] = 0;
                m_per[i] = 1'b0;
                m_exp[i] = 1'b0;
            end
        end else begin
            nt = 1'b0;
            if (EN) begin
                m_en_edges++;
                nt = (m_en_edges % DIV) == 0;
            end
            for (int i = 0; i < NUM_CH; i++) begin
                ld = int'(load_val[i*CNT_W +: CNT_W]);
                m_exp[i] = 1'b0;
                if (stop[i]) begin
                    if (m_run[i]) begin
                        m_run[i] = 1'b0;
                        m_rem[i] = 0;
                    end
                end else if (start[i] && ld != 0) begin
                    m_rem[i] = ld;
                    m_rld[i] = ld;
                    m_per[i] = periodic[i];
                    m_run[i] = 1'b1;
                end else if (m_run[i] && m_tick) begin
                    m_rem[i] = m_rem[i] - 1;
                    if (m_rem[i] == 0) begin
                        m_exp[i] = 1'b1;
                        if (m_per[i]) m_rem[i] = m_rld[i];
                        else m_run[i] = 1'b0;
                    end
                end
            end
            m_tick = nt;
        end
    endtask

    task automatic model_check();
        logic [NUM_CH-1:0]       e_exp;
        logic [NUM_CH-1:0]       e_busy;
        logic [NUM_CH*CNT_W-1:0] e_rem;
        for (int i = 0; i < NUM_CH; i++) begin
            e_exp[i]                  = m_exp[i];
            e_busy[i]                 = m_run[i];
            e_rem[i*CNT_W +: CNT_W]   = CNT_W'(m_rem[i]);
        end
        chk("m_tick", 32'(tick), 32'(m_tick));
        chk("m_expired", 32'(expired), 32'(e_exp));
        chk("m_busy", 32'(busy), 32'(e_busy));
        chk("m_remaining", 32'(remaining), 32'(e_rem));
    endtask

    task automatic step();
        if (model_on) model_edge();
        @(posedge CLK);
        #1;
        cyc++;
        if (model_on) model_check();
    endtask

    task automatic do_reset();
        RST      = 1'b1;
        EN       = 1'b0;
        start    = '0;
        stop     = '0;
        periodic = '0;
        load_val = '0;
        step();
        step();
        RST = 1'b0;
        EN  = 1'b1;
        cyc = 0;
    endtask

    task automatic wait_tick();
        int n;
        n = 0;
        while (tick !== 1'b1 && n < 3 * DIV) begin
            step();
            n++;
        end
        chk("tick_wait", 32'(tick), 1);
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int got [3];
        int k;
        int nexp;
        int busy_bad;
        int ec [3];
        int rr [3];

        tbl[0] = '{gap_at: 0,  gap_len: 0, t: '{10, 20, 30}};
        tbl[1] = '{gap_at: 12, gap_len: 5, t: '{10, 25, 35}};
        tbl[2] = '{gap_at: 3,  gap_len: 2, t: '{12, 22, 32}};

        RST      = 1'b1;
        EN       = 1'b0;
        start    = '0;
        stop     = '0;
        periodic = '0;
        load_val = '0;

        // Reset state
        do_reset();
        chk("rst_tick", 32'(tick), 0);
        chk("rst_expired", 32'(expired), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_remaining", 32'(remaining), 0);

        // Prescaler: tick cycles with and without an EN gap
        for (int r = 0; r < 3; r++) begin
            do_reset();
            k = 0;
            got = '{-1, -1, -1};
            for (int c = 1; c <= 40; c++) begin
                EN = !(tbl[r].gap_len != 0 &&
                       c - 1 >= tbl[r].gap_at &&
                       c - 1 <  tbl[r].gap_at + tbl[r].gap_len);
                step();
                if (tick === 1'b1 && k < 3) begin
                    got[k] = cyc;
                    k++;
                end
            end
            EN = 1'b1;
            for (int j = 0; j < 3; j++)
                chk($sformatf("tick%0d_row%0d", j, r), got[j], tbl[r].t[j]);
        end

        // ch0 one-shot of 3
        do_reset();
        start    = 2'b01;
        load_val = {8'd0, 8'd3};
        step();
        start = '0;
        chk("a_busy", 32'(busy[0]), 1);
        chk("a_rem", 32'(remaining[7:0]), 3);
        for (int n = 2; n >= 0; n--) begin
            wait_tick();
            step();
            chk("a_rem_tick", 32'(remaining[7:0]), n);
            chk("a_exp_tick", 32'(expired[0]), 32'(n == 0));
            chk("a_busy_tick", 32'(busy[0]), 32'(n != 0));
        end
        step();
        chk("a_exp_clear", 32'(expired[0]), 0);

        // ch1 periodic of 2
        do_reset();
        start    = 2'b10;
        periodic = 2'b10;
        load_val = {8'd2, 8'd0};
        step();
        start    = '0;
        periodic = '0;
        nexp     = 0;
        busy_bad = 0;
        ec       = '{-1, -1, -1};
        rr       = '{-1, -1, -1};
        while (cyc < 65) begin
            step();
            if (busy[1] !== 1'b1) busy_bad++;
            if (cyc == 11) chk("b_rem_c11", 32'(remaining[15:8]), 1);
            if (expired[1] === 1'b1) begin
                if (nexp < 3) begin
                    ec[nexp] = cyc;
                    rr[nexp] = int'(remaining[15:8]);
                end
                nexp++;
            end
        end
        chk("b_nexp", nexp, 3);
        chk("b_exp0", ec[0], 21);
        chk("b_exp1", ec[1], 41);
        chk("b_exp2", ec[2], 61);
        for (int j = 0; j < 3; j++) chk("b_reload", rr[j], 2);
        chk("b_busy_drops", busy_bad, 0);

        // stop on the same cycle as the final tick, then zero start
        do_reset();
        start    = 2'b01;
        load_val = {8'd0, 8'd2};
        step();
        start = '0;
        while (cyc < 20) step();
        chk("c_tick20", 32'(tick), 1);
        chk("c_rem1", 32'(remaining[7:0]), 1);
        stop = 2'b01;
        step();
        stop = '0;
        chk("c_exp", 32'(expired[0]), 0);
        chk("c_busy", 32'(busy[0]), 0);
        chk("c_rem", 32'(remaining[7:0]), 0);
        start    = 2'b01;
        load_val = '0;
        step();
        start = '0;
        chk("c_zero_busy", 32'(busy[0]), 0);
        chk("c_zero_rem", 32'(remaining[7:0]), 0);
        step();
        chk("c_exp_late", 32'(expired[0]), 0);

        // restart over the final tick, then reset drops a pending expiry
        do_reset();
        start    = 2'b01;
        load_val = {8'd0, 8'd2};
        step();
        start = '0;
        while (cyc < 20) step();
        chk("d_tick20", 32'(tick), 1);
        chk("d_rem1", 32'(remaining[7:0]), 1);
        start    = 2'b11;
        periodic = 2'b10;
        load_val = {8'd1, 8'd5};
        step();
        start    = '0;
        periodic = '0;
        load_val = '0;
        chk("d_rem5", 32'(remaining[7:0]), 5);
        chk("d_exp", 32'(expired), 0);
        chk("d_busy", 32'(busy), 3);
        chk("d_rem_ch1", 32'(remaining[15:8]), 1);
        while (cyc < 30) step();
        chk("d_tick30", 32'(tick), 1);
        RST = 1'b1;
        step();
        RST = 1'b0;
        chk("d_rst_busy", 32'(busy), 0);
        chk("d_rst_rem", 32'(remaining), 0);
        chk("d_rst_exp", 32'(expired), 0);
        chk("d_rst_tick", 32'(tick), 0);

        // Random traffic against the model
        model_on = 1'b1;
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            RST = ($urandom_range(0, 799) == 0);
            EN  = ($urandom_range(0, 9) != 0);
            for (int i = 0; i < NUM_CH; i++) begin
                start[i]    = ($urandom_range(0, 29) == 0);
                stop[i]     = ($urandom_range(0, 59) == 0);
                periodic[i] = $urandom_range(0, 1) != 0;
                load_val[i*CNT_W +: CNT_W] = CNT_W'($urandom_range(0, 6));
            end
            step();
        end
        model_on = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_fail);
        $finish;
    end

endmodule
